// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and launch FSM state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BUSY  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: register-array storage, natural-wrap pointers, registered count/empty/full.
module sync_fifo #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_ok;
    logic              rd_ok;
    logic [ADDR_W:0]   count_next;

    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    // Next occupancy from the accepted read/write pair.
    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and registered occupancy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == FULL_CNT);
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer and launch sequencer feeding an 8-bit UART transmitter.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx_start,
    output logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_busy,
    output logic [ADDR_W:0]        fifo_count,
    output logic                   fifo_empty,
    output logic                   fifo_full
);

    tx_state_t              state;
    logic                   push;
    logic                   pop;
    logic [UART_DATA_W-1:0] head;

    // in_ready derives only from the registered full flag.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && !fifo_empty && !tx_busy;

    sync_fifo #(
        .DATA_W (UART_DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Launch FSM: pop into tx_data, hold tx_start until busy is seen, then wait for busy to clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= head;
                        tx_start <= 1'b1;
                        state    <= ARMED;
                    end
                end
                ARMED: begin
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder with a behavioural transmitter and an in-order scoreboard.
module tb_uart_tx_feeder;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned BUSY_N = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic [4:0] fifo_count;
    logic       fifo_empty;
    logic       fifo_full;

    logic        stall  = 1'b0;
    logic        busy_m = 1'b0;
    int unsigned busy_cnt = 0;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  launch_q[$];
    int unsigned gap_q[$];

    int unsigned cyc       = 0;
    int unsigned fall_cyc  = 0;
    logic        gap_valid = 1'b0;
    logic        prev_busy = 1'b0;
    logic        prev_start = 1'b0;

    always #5 clk = ~clk;

    // The transmitter line is busy either from the model or from a foreign stall.
    assign tx_busy = busy_m | stall;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full)
    );

    // Transmitter model: accepts a start when idle, busy rises next cycle and lasts BUSY_N cycles.
    always @(posedge clk) begin
        if (busy_m) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) busy_m <= 1'b0;
        end else if (tx_start && !stall) begin
            busy_m   <= 1'b1;
            busy_cnt <= BUSY_N;
            launch_q.push_back(tx_data);
        end
    end

    // Gap monitor: cycles from busy falling to the next tx_start rise.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (prev_busy && !tx_busy) begin
            fall_cyc  <= cyc;
            gap_valid <= 1'b1;
        end else if (!prev_start && tx_start) begin
            if (gap_valid) gap_q.push_back(cyc - fall_cyc);
            gap_valid <= 1'b0;
        end
        prev_busy  <= tx_busy;
        prev_start <= tx_start;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge after the accepting edge, in_valid left high.
    task automatic push_byte(input logic [7:0] b, input int unsigned max_wait);
        int unsigned n = 0;
        logic rdy;
        logic done = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        while (!done && n < max_wait) begin
            rdy = in_ready;
            @(negedge clk);
            n++;
            if (rdy) begin
                exp_q.push_back(b);
                done = 1'b1;
            end
        end
        chk("push_accept", 32'(done), 32'd1);
    endtask

    task automatic wait_drain(input string tag);
        int unsigned n = 0;
        while ((launch_q.size() != exp_q.size() || busy_m || tx_start) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 3000), 32'd1);
    endtask

    task automatic cmp_seq(input string tag);
        chk($sformatf("%s_len", tag), launch_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < launch_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(launch_q[i]), 32'(exp_q[i]));
        exp_q.delete();
        launch_q.delete();
    endtask

    initial begin
        logic [7:0] base;
        logic [7:0] first;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1. Single byte, launch latency two cycles from driving the push.
        push_byte(8'hA5, 5);
        in_valid = 1'b0;
        chk("t1_start_early", 32'(tx_start), 32'd0);
        chk("t1_count", 32'(fifo_count), 32'd1);
        @(negedge clk);
        chk("t1_start", 32'(tx_start), 32'd1);
        chk("t1_data", 32'(tx_data), 32'hA5);
        wait_drain("t1_drain");
        cmp_seq("t1");
        chk("t1_count_end", 32'(fifo_count), 32'd0);
        chk("t1_empty_end", 32'(fifo_empty), 32'd1);

        // 2. Burst of five, 2-cycle gap from busy falling to next start.
        gap_q.delete();
        for (int i = 1; i <= 5; i++) push_byte(8'(i), 5);
        in_valid = 1'b0;
        wait_drain("t2_drain");
        cmp_seq("t2");
        chk("t2_gaps", gap_q.size(), 32'd5);
        for (int i = 1; i < 5 && i < gap_q.size(); i++)
            chk($sformatf("t2_gap%0d", i), gap_q[i], 32'd2);

        // 3. Fill with the transmitter stalled; the 17th byte waits.
        stall = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom), 5);
        in_data = 8'($urandom);
        repeat (4) @(negedge clk);
        chk("t3_count", 32'(fifo_count), DEPTH);
        chk("t3_full", 32'(fifo_full), 32'd1);
        chk("t3_ready", 32'(in_ready), 32'd0);
        chk("t3_no_launch", launch_q.size(), 32'd0);

        // 4. Release while the producer holds valid; the held byte refills the freed slot.
        stall = 1'b0;
        push_byte(in_data, 20);
        in_valid = 1'b0;
        chk("t4_count", 32'(fifo_count), DEPTH);
        chk("t4_full", 32'(fifo_full), 32'd1);
        wait_drain("t4_drain");
        cmp_seq("t4");

        // 5. Stream 40 incrementing bytes with random producer gaps across pointer wrap.
        base = 8'($urandom_range(0, 255));
        for (int i = 0; i < 40; i++) begin
            push_byte(base + 8'(i), 200);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
        end
        in_valid = 1'b0;
        wait_drain("t5_drain");
        cmp_seq("t5");

        // 6. Reset mid-burst: first byte is in flight, six remain queued and are discarded.
        for (int i = 0; i < 7; i++) push_byte(8'($urandom), 5);
        in_valid = 1'b0;
        chk("t6_count_pre", 32'(fifo_count), 32'd6);
        first = exp_q[0];
        rst_n = 1'b0;
        #1;
        chk("t6_rst_start", 32'(tx_start), 32'd0);
        chk("t6_rst_count", 32'(fifo_count), 32'd0);
        chk("t6_rst_empty", 32'(fifo_empty), 32'd1);
        chk("t6_rst_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_q.push_back(first);
        repeat (60) @(negedge clk);
        chk("t6_no_start", 32'(tx_start), 32'd0);
        cmp_seq("t6_flush");
        push_byte(8'h3C, 5);
        in_valid = 1'b0;
        wait_drain("t6_drain");
        cmp_seq("t6_new");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
